// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides clk into sequencer steps, emits quarter/half-frame
// pulses, owns the frame IRQ flag and the mode/inhibit control register.
module apu_frame_sequencer #(
  parameter int STEP_LEN = 7457,
  parameter int WR_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_data,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step,
  output logic       mode
);
  localparam int CW = $clog2(STEP_LEN);

  logic [CW-1:0] cnt;
  logic [2:0]    dly;
  logic          new_mode;
  logic          inhibit;

  logic       term, restart;
  logic [2:0] last_step;
  logic       ev_q, ev_h, ev_irq;

  // A write landing on the restart edge reloads the delay, so it cancels that restart.
  always_comb begin
    term      = (cnt == CW'(STEP_LEN - 1));
    restart   = !wr_en && (dly == 3'd1);
    last_step = mode ? 3'd4 : 3'd3;
    ev_q      = 1'b0;
    ev_h      = 1'b0;
    ev_irq    = 1'b0;
    case (step)
      3'd0: ev_q = 1'b1;
      3'd1: begin ev_q = 1'b1; ev_h = 1'b1; end
      3'd2: ev_q = 1'b1;
      3'd3: if (!mode) begin ev_q = 1'b1; ev_h = 1'b1; ev_irq = !inhibit; end
      3'd4: begin ev_q = 1'b1; ev_h = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      step          <= 3'd0;
      mode          <= 1'b0;
      inhibit       <= 1'b0;
      new_mode      <= 1'b0;
      dly           <= 3'd0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_irq     <= 1'b0;
    end else begin
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;

      // Restart overrides the terminal step event of the same edge.
      if (restart) begin
        cnt           <= '0;
        step          <= 3'd0;
        mode          <= new_mode;
        quarter_frame <= new_mode;
        half_frame    <= new_mode;
      end else if (term) begin
        cnt           <= '0;
        step          <= (step == last_step) ? 3'd0 : step + 3'd1;
        quarter_frame <= ev_q;
        half_frame    <= ev_h;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (wr_en) begin
        dly      <= 3'(WR_DELAY);
        new_mode <= wr_data[1];
        inhibit  <= wr_data[0];
      end else if (dly != 3'd0) begin
        dly <= dly - 3'd1;
      end

      // Priority: inhibit write clears, then IRQ set, then acknowledge.
      if (wr_en && wr_data[0])
        frame_irq <= 1'b0;
      else if (!restart && term && ev_irq)
        frame_irq <= 1'b1;
      else if (irq_ack)
        frame_irq <= 1'b0;
    end
  end
endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
Frame sequencer for the APU. It divides the APU clock into roughly 240 Hz steps and issues one-cycle quarter-frame and half-frame enable pulses. These pulses drive the channel envelope, linear-counter, length-counter and sweep units. The block also owns the frame-IRQ flag and the mode/inhibit control register (the $4017 equivalent), which the UART command decoder writes.

Parameters:
STEP_LEN, 7457, clk cycles per sequencer step (~240 Hz at 1.789773 MHz); legal range 2..32767.
WR_DELAY, 3, clk cycles from a control write to sequencer restart; legal range 1..7.

Ports:
clk  input  1  system/APU clock, 1.789773 MHz
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  one-cycle control register write strobe
wr_data  input  2  [1]=mode (0: 4-step, 1: 5-step); [0]=irq_inhibit
irq_ack  input  1  one-cycle status-read strobe; clears frame_irq
quarter_frame  output  1  one-cycle pulse, clocks envelopes and linear counter
half_frame  output  1  one-cycle pulse, clocks length counters and sweeps
frame_irq  output  1  level, frame interrupt flag
step  output  3  current step index, 0..3 in mode 0, 0..4 in mode 1
mode  output  1  active sequencer mode

Behaviour:
- Clocking and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset values: cnt=0, step=0, mode=0, inhibit=0, quarter_frame=0, half_frame=0, frame_irq=0. Any pending write is discarded.
- Output timing: all outputs are registered. Pulses are high for exactly the one cycle following the edge that generates them.
- Counter: cnt increments every clk edge.
  - At an edge with cnt==STEP_LEN-1: cnt<=0, step advances, and the event for the completed step fires.
  - First event after reset is therefore at edge STEP_LEN.
- Mode 0 (4-step) events:
  - step 0 done: Q
  - step 1 done: Q+H
  - step 2 done: Q
  - step 3 done: Q+H; frame_irq<=1 if inhibit==0; step wraps to 0
- Mode 1 (5-step) events:
  - step 0 done: Q
  - step 1 done: Q+H
  - step 2 done: Q
  - step 3 done: nothing
  - step 4 done: Q+H; step wraps to 0
  - Mode 1 never sets frame_irq.
- Control write, inhibit path: on the wr_en edge, inhibit<=wr_data[0] immediately. If wr_data[0]==1, frame_irq<=0 on that same edge.
- Control write, mode/restart path: new_mode<=wr_data[1] and the delay counter loads WR_DELAY.
  - The old mode keeps running, with normal events, while the write is pending.
  - At the edge WR_DELAY cycles after the write edge: cnt<=0, step<=0, mode<=new_mode.
  - If new_mode==1, Q and H pulse together after that restart edge. If new_mode==0, no pulse.
- Second write while pending: re-samples wr_data and reloads WR_DELAY. Last write wins; inhibit updates immediately.
- Restart coinciding with cnt==STEP_LEN-1: restart wins. The terminal event (Q/H/IRQ) is suppressed; only the mode-1 restart pulse may appear.
- frame_irq persistence: stays high until irq_ack or an inhibit=1 write.
- Same-edge IRQ set and irq_ack: set wins, frame_irq stays 1.
- Same-edge IRQ set and inhibit=1 write: clear wins, frame_irq=0.
- Width rules: cnt is ceil(log2(STEP_LEN)) bits; the delay counter is 3 bits. No value exceeds its range.

Test Plan:
Use STEP_LEN=8, WR_DELAY=3; edges are numbered from reset release (edge 1).
1. Reset, no writes:
   - Q high after edges 8, 16, 24, 32, 40…
   - H high after edges 16, 32.
   - frame_irq rises after edge 32 and stays high.
   - step sequence 1, 2, 3, 0.
2. Continue from 1; irq_ack at edge 40 -> frame_irq low after edge 40; rises again after edge 64.
3. Write mode=1 (wr_data=2'b10) at edge 5:
   - No Q at edge 8 (restart coincides); restart at edge 8 emits Q+H together, step=0, mode=1.
   - Then Q at edges 16, 24, 32, 48 and H at 24, 48.
   - frame_irq never asserts over 200 cycles.
4. frame_irq high, write wr_data=2'b01 -> frame_irq low after that edge; no IRQ over 100 further cycles in mode 0.
5. IRQ set at edge 32 and irq_ack on edge 32 -> frame_irq=1. Repeat with inhibit=1 write on edge 32 -> frame_irq=0.
6. Write mode=1 at edge 4, then mode=0 at edge 6:
   - Single restart at edge 9 with mode=0 and no pulse.
   - Assert rst_n low mid-step afterwards -> all outputs 0 asynchronously; no restart fires after release.
